byte_serial_add_seq: RTL and testbench

Sequencer that performs an N-byte addition by time-multiplexing the team's 8-bit ripple-carry adder stage (two 8-bit operands plus carry-in, 9-bit result). It is the stage directly upstream and downstream of that adder. It slices wide operands into bytes and drives them into the adder LSB-first, then collects each 9-bit result and chains bit 8 back as the next carry-in. Handshakes are valid/ready on both the input and output sides.

---
 rtl/byte_serial_add_seq.sv | 118 +++++++++++
 tb/tb_byte_serial_add_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_add_seq.sv
// Byte-serial N-byte adder sequencer: feeds an external 8-bit adder LSB-first,
// chains its carry-out back in, and returns the (W+1)-bit sum over valid/ready.
module byte_serial_add_seq #(
   parameter  int NBYTES = 4,
   localparam int W      = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         cin_in,
   output logic [7:0]   add_a,
   output logic [7:0]   add_b,
   output logic         add_cin,
   input  logic [8:0]   add_s,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   sum,
   output logic         busy,
   output logic [1:0]   dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both
   // high. in_ready is high only in IDLE; out_valid only in DONE, and sum is held
   // stable until out_ready is seen. The two sides never overlap in one cycle.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int              IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0]   LAST = IW'(NBYTES - 1);

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_idx;
   logic            r_carry;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W:0]      r_sum;
   logic            w_last;

   assign w_last    = (r_idx == LAST);
   assign sum       = r_sum;
   assign dbg_state = r_state;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      add_a     = 8'd0;
      add_b     = 8'd0;
      add_cin   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = S_RUN;
         end
         S_RUN: begin
            busy    = 1'b1;
            add_a   = r_a[8*r_idx +: 8];
            add_b   = r_b[8*r_idx +: 8];
            add_cin = r_carry;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Index wraps to 0 on the last byte so it never exceeds NBYTES-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_carry <= cin_in;
                  r_idx   <= '0;
               end
            end
            S_RUN: begin
               r_sum[8*r_idx +: 8] <= add_s[7:0];
               r_carry             <= add_s[8];
               if (w_last) begin
                  r_sum[W] <= add_s[8];
                  r_idx    <= '0;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_serial_add_seq.sv
// Bench for byte_serial_add_seq: a 4-byte and a 1-byte instance, each with a
// behavioural adder, checked every cycle against an arithmetic timing model.
module tb_byte_serial_add_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  iv, ir, cin, ov, ordy, bsy, acin;
   logic [31:0] opa [2];
   logic [31:0] opb [2];
   logic [7:0]  aa  [2];
   logic [7:0]  ab  [2];
   logic [8:0]  as_ [2];
   logic [1:0]  dbg0, dbg1;
   logic [32:0] sum0;
   logic [8:0]  sum1;

   int          n_vec = 0;
   int          n_err = 0;
   int          e = 0;
   bit          started = 0;
   bit          rnd_on = 0;

   bit          act [2];
   int          t0  [2];
   logic [63:0] ma  [2];
   logic [63:0] mb  [2];
   logic        mc  [2];

   // External 8-bit ripple adders, one per instance
   assign as_[0] = 9'(aa[0]) + 9'(ab[0]) + 9'(acin[0]);
   assign as_[1] = 9'(aa[1]) + 9'(ab[1]) + 9'(acin[1]);

   byte_serial_add_seq #(.NBYTES(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .op_a(opa[0]), .op_b(opb[0]), .cin_in(cin[0]),
      .add_a(aa[0]), .add_b(ab[0]), .add_cin(acin[0]), .add_s(as_[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum0), .busy(bsy[0]),
      .dbg_state(dbg0)
   );

   byte_serial_add_seq #(.NBYTES(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .op_a(opa[1][7:0]), .op_b(opb[1][7:0]), .cin_in(cin[1]),
      .add_a(aa[1]), .add_b(ab[1]), .add_cin(acin[1]), .add_s(as_[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum1), .busy(bsy[1]),
      .dbg_state(dbg1)
   );

   function automatic int nb(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic logic [63:0] wmask(input int i);
      return (i == 0) ? 64'hFFFF_FFFF : 64'hFF;
   endfunction

   function automatic logic [63:0] get_sum(input int i);
      return (i == 0) ? 64'(sum0) : 64'(sum1);
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at edge %0d", nm, got, exp, e);
      end
   endtask

   // Model: an operation occupies the block from its accept edge t0; byte k is on
   // the adder after edge t0+k, the result is offered from edge t0+N onward.
   always @(posedge clk) begin
      e++;
      for (int i = 0; i < 2; i++) begin
         if (rst) act[i] = 1'b0;
         else if (act[i] && (e - t0[i] > nb(i)) && ordy[i]) act[i] = 1'b0;
         else if (!act[i] && iv[i]) begin
            act[i] = 1'b1;
            t0[i]  = e;
            ma[i]  = 64'(opa[i]) & wmask(i);
            mb[i]  = 64'(opb[i]) & wmask(i);
            mc[i]  = cin[i];
         end
      end
      if (rst) started = 1'b1;
   end

   always @(negedge clk) begin
      int          k;
      bit          run, eov;
      logic [63:0] msk, ea, eb, ec;
      string       p;
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            p   = (i == 0) ? "u4" : "u1";
            k   = e - t0[i];
            run = act[i] && (k < nb(i));
            eov = act[i] && (k >= nb(i));
            ea  = 0; eb = 0; ec = 0;
            if (run) begin
               msk = (64'd1 << (8 * k)) - 1;
               ea  = (ma[i] >> (8 * k)) & 64'hFF;
               eb  = (mb[i] >> (8 * k)) & 64'hFF;
               ec  = (((ma[i] & msk) + (mb[i] & msk) + 64'(mc[i])) >> (8 * k)) & 64'd1;
            end
            chk({p, ".in_ready"},  64'(ir[i]),   64'(!act[i]));
            chk({p, ".busy"},      64'(bsy[i]),  64'(act[i]));
            chk({p, ".out_valid"}, 64'(ov[i]),   64'(eov));
            chk({p, ".add_a"},     64'(aa[i]),   ea);
            chk({p, ".add_b"},     64'(ab[i]),   eb);
            chk({p, ".add_cin"},   64'(acin[i]), ec);
            if (eov) chk({p, ".sum"}, get_sum(i), ma[i] + mb[i] + 64'(mc[i]));
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_on) begin
         #1;
         ordy[0] = ($urandom_range(0, 3) != 0);
         ordy[1] = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic c,
                        output int acc_e);
      bit got;
      @(posedge clk); #1;
      iv[0] = 1'b1; opa[0] = a; opb[0] = b; cin[0] = c;
      got = 1'b0;
      for (int g = 0; g < 50 && !got; g++) begin
         @(negedge clk);
         got = ir[0];
      end
      chk("send0.accept_wait", 64'(got), 64'd1);
      @(posedge clk); #1;
      acc_e = e;
      iv[0] = 1'b0;
   endtask

   task automatic wait_ov0(input int acc_e, output int lat);
      lat = -1;
      for (int g = 0; g < 40; g++) begin
         @(negedge clk);
         if (ov[0]) begin
            lat = e - acc_e;
            break;
         end
      end
   endtask

   task automatic hs0();
      @(posedge clk); #1 ordy[0] = 1'b1;
      @(posedge clk); #1 ordy[0] = 1'b0;
   endtask

   task automatic drv(input int i);
      bit got;
      for (int n = 0; n < 1000; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         @(posedge clk); #1;
         iv[i] = 1'b1; opa[i] = $urandom; opb[i] = $urandom; cin[i] = $urandom_range(0, 1);
         got = 1'b0;
         for (int g = 0; g < 60 && !got; g++) begin
            @(negedge clk);
            got = ir[i];
         end
         if (!got) begin
            chk("drv.accept_wait", 64'(got), 64'd1);
            break;
         end
         @(posedge clk); #1;
         iv[i] = 1'b0;
      end
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int          acc, lat;
      int          accs [5];
      logic [7:0]  xa   [4];
      logic        xc   [4];
      logic [32:0] held;
      xa = '{8'hFF, 8'h00, 8'hFF, 8'h00};
      xc = '{1'b1, 1'b1, 1'b0, 1'b1};
      iv = '0; ordy = '0; cin = '0;
      opa = '{32'd0, 32'd0}; opb = '{32'd0, 32'd0};
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("reset.in_ready", 64'(ir), 64'h3);
      chk("reset.out_valid", 64'(ov), 64'h0);
      chk("reset.busy", 64'(bsy), 64'h0);
      chk("reset.sum4", 64'(sum0), 64'h0);
      chk("reset.add_a", 64'(aa[0]), 64'h0);

      // Full-width carry ripple into bit 32
      send0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, acc);
      wait_ov0(acc, lat);
      chk("t1.latency", 64'(lat), 64'd4);
      chk("t1.sum", 64'(sum0), 64'h1_0000_0000);
      hs0();

      // Per-byte adder inputs and carry chain
      send0(32'h00FF_00FF, 32'h0001_0001, 1'b1, acc);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk($sformatf("t2.add_a[%0d]", j), 64'(aa[0]), 64'(xa[j]));
         chk($sformatf("t2.add_cin[%0d]", j), 64'(acin[0]), 64'(xc[j]));
      end
      wait_ov0(acc, lat);
      chk("t2.sum", 64'(sum0), 64'h0_0100_0101);
      hs0();

      // Backpressure: result held for 5 cycles
      send0(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, acc);
      wait_ov0(acc, lat);
      chk("t3.sum", 64'(sum0), 64'h0_F0E2_1568);
      held = sum0;
      repeat (5) begin
         @(negedge clk);
         chk("t3.hold_valid", 64'(ov[0]), 64'd1);
         chk("t3.hold_ready", 64'(ir[0]), 64'd0);
         chk("t3.hold_sum", 64'(sum0), 64'(held));
      end
      @(posedge clk); #1 ordy[0] = 1'b1;
      @(posedge clk); #1 ordy[0] = 1'b0;
      @(negedge clk);
      chk("t3.after_valid", 64'(ov[0]), 64'd0);
      chk("t3.after_ready", 64'(ir[0]), 64'd1);

      // Reset after the second RUN edge aborts the operation
      send0(32'h1234_5678, 32'h1111_1111, 1'b0, acc);
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t4.in_ready", 64'(ir[0]), 64'd1);
      chk("t4.out_valid", 64'(ov[0]), 64'd0);
      chk("t4.sum", 64'(sum0), 64'd0);
      chk("t4.add", 64'({aa[0], ab[0], acin[0]}), 64'd0);
      send0(32'd1, 32'd1, 1'b0, acc);
      wait_ov0(acc, lat);
      chk("t4.sum_1p1", 64'(sum0), 64'd2);
      hs0();

      // Back-to-back with in_valid held high: one accept per NBYTES+2 edges
      @(posedge clk); #1;
      ordy[0] = 1'b1; iv[0] = 1'b1;
      for (int j = 0; j < 5; j++) begin
         bit got;
         opa[0] = $urandom; opb[0] = $urandom; cin[0] = $urandom_range(0, 1);
         got = 1'b0;
         for (int g = 0; g < 20 && !got; g++) begin
            @(negedge clk);
            got = ir[0];
         end
         chk("t5.accept_wait", 64'(got), 64'd1);
         @(posedge clk); #1;
         accs[j] = e;
         if (j > 0) chk("t5.interval", 64'(accs[j] - accs[j-1]), 64'd6);
      end
      iv[0] = 1'b0;
      repeat (8) @(posedge clk);

      // Randomized traffic on both widths
      rnd_on = 1'b1;
      fork
         drv(0);
         drv(1);
      join
      rnd_on = 1'b0;
      @(posedge clk); #2 ordy = 2'b11;
      repeat (10) @(posedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
